// File: rtl/fp_shift_pipe.sv
// fp_shift_pipe: two-stage pipelined barrel shifter for FP mantissa alignment
// and normalisation. It does logical right, arithmetic right and logical left
// shifts, and produces a sticky bit (OR of every discarded input bit).
// Valid/ready handshakes are on both sides. Shift amounts of WIDTH or more
// saturate.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  upstream handshake
//   in_data            operand
//   in_shamt           unsigned shift amount
//   in_dir             0 = right, 1 = left
//   in_arith           sign-fill on right shifts
//   in_tag             sideband tag, returned unchanged
//   out_valid/out_ready downstream handshake
//   out_data           shifted result
//   out_sticky         OR of the bits shifted out of the window
//   out_tag            tag of this result
module fp_shift_pipe #(
  parameter int WIDTH   = 24,
  parameter int SHAMT_W = 8,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_dir,
  input  logic               in_arith,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic [TAG_W-1:0]   out_tag
);
  // Amount is clamped to WIDTH, so AW bits always hold it.
  localparam int AW = $clog2(WIDTH + 1);
  localparam int LO = AW / 2;
  localparam int HI = AW - LO;
  localparam int XW = 2 * WIDTH;
  localparam int CW = ((SHAMT_W > AW) ? SHAMT_W : AW) + 1;

  // The operand sits in a double-width window: the result half and the
  // discard half. A right shift starts with the operand in the upper half,
  // a left shift starts with it in the lower half. Once the amount is clamped
  // to WIDTH, no operand bit can fall off the window. The discard half
  // therefore holds exactly the dropped bits, and fill bits never reach it.
  logic             s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic             s1_ld, s2_ld;
  logic [XW-1:0]    s1_vec_q, s1_vec_d;
  logic [HI-1:0]    s1_hi_q, s1_hi_d;
  logic             s1_dir_q, s1_ari_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_stk_q, s2_stk_d;
  logic [TAG_W-1:0] s2_tag_q;

  logic             sat;
  logic [AW-1:0]    amt_c;
  logic [XW-1:0]    ext, v2;
  logic [AW-1:0]    sh2;

  assign s2_ld    = !s2_vld_q || out_ready;
  assign s1_ld    = !s1_vld_q || s2_ld;
  assign in_ready = s1_ld;

  assign s1_vld_d = s1_ld ? in_valid : s1_vld_q;
  assign s2_vld_d = s2_ld ? s1_vld_q : s2_vld_q;

  assign sat   = CW'(in_shamt) >= CW'(WIDTH);
  assign amt_c = sat ? AW'(WIDTH) : AW'(in_shamt);

  // Stage 1: shift by the low-order amount bits, and keep the high bits for s2.
  always_comb begin
    ext = in_dir ? {{WIDTH{1'b0}}, in_data} : {in_data, {WIDTH{1'b0}}};
    if (in_dir)        s1_vec_d = ext << amt_c[LO-1:0];
    else if (in_arith) s1_vec_d = $unsigned($signed(ext) >>> amt_c[LO-1:0]);
    else               s1_vec_d = ext >> amt_c[LO-1:0];
    s1_hi_d = amt_c[AW-1:LO];
  end

  // Stage 2: finish the shift, then split the window into result and sticky.
  always_comb begin
    sh2 = {s1_hi_q, {LO{1'b0}}};
    if (s1_dir_q)      v2 = s1_vec_q << sh2;
    else if (s1_ari_q) v2 = $unsigned($signed(s1_vec_q) >>> sh2);
    else               v2 = s1_vec_q >> sh2;
    if (s1_dir_q) begin
      s2_data_d = v2[WIDTH-1:0];
      s2_stk_d  = |v2[XW-1:WIDTH];
    end else begin
      s2_data_d = v2[XW-1:WIDTH];
      s2_stk_d  = |v2[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_stk_q  <= 1'b0;
      s2_tag_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      if (s1_ld && in_valid) begin
        s1_vec_q <= s1_vec_d;
        s1_hi_q  <= s1_hi_d;
        s1_dir_q <= in_dir;
        s1_ari_q <= in_arith && !in_dir;
        s1_tag_q <= in_tag;
      end
      if (s2_ld && s1_vld_q) begin
        s2_data_q <= s2_data_d;
        s2_stk_q  <= s2_stk_d;
        s2_tag_q  <= s1_tag_q;
      end
    end
  end

  assign out_valid  = s2_vld_q;
  assign out_data   = s2_data_q;
  assign out_sticky = s2_stk_q;
  assign out_tag    = s2_tag_q;
endmodule

// File: tb/tb_fp_shift_pipe.sv
module tb_fp_shift_pipe;
  localparam int W = 24;

  typedef struct packed {
    logic [W-1:0] d;
    logic         s;
    logic [3:0]   t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_dir, in_arith;
  logic [W-1:0] in_data;
  logic [7:0]   in_shamt;
  logic [3:0]   in_tag;
  logic         out_valid, out_ready, out_sticky;
  logic [W-1:0] out_data;
  logic [3:0]   out_tag;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_shift_pipe #(.WIDTH(W), .SHAMT_W(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_dir(in_dir), .in_arith(in_arith), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .out_tag(out_tag)
  );

  // Reference model: works bit by bit from the shift definition.
  function automatic exp_t ref_op(logic [W-1:0] d, logic [7:0] sa, logic dr,
                                  logic ar, logic [3:0] tg);
    exp_t r;
    int a;
    logic fill;
    a    = (int'(sa) >= W) ? W : int'(sa);
    fill = (!dr && ar) ? d[W-1] : 1'b0;
    r.d  = '0;
    r.s  = 1'b0;
    r.t  = tg;
    for (int i = 0; i < W; i++) begin
      if (dr) r.d[i] = (i >= a) ? d[i-a] : 1'b0;
      else    r.d[i] = (i + a < W) ? d[i+a] : fill;
    end
    for (int j = 0; j < W; j++) begin
      if (dr) begin
        if (j >= W - a) r.s = r.s | d[j];
      end else begin
        if (j < a) r.s = r.s | d[j];
      end
    end
    return r;
  endfunction

  // Applies inputs for one cycle, samples outputs mid-cycle, then steps one clock.
  task automatic cycle(input logic r, input logic v, input logic [W-1:0] d,
                       input logic [7:0] sa, input logic dr, input logic ar,
                       input logic [3:0] tg, input logic ordy,
                       output logic ov, output logic ir, output logic [W-1:0] od,
                       output logic os, output logic [3:0] ot);
    rst = r; in_valid = v; in_data = d; in_shamt = sa; in_dir = dr;
    in_arith = ar; in_tag = tg; out_ready = ordy;
    #1;
    ov = out_valid; ir = in_ready; od = out_data; os = out_sticky; ot = out_tag;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One op into an idle pipe with out_ready=1. lat counts cycles from the
  // accept cycle to the first out_valid cycle, and is -1 on timeout.
  task automatic one_op(input logic [W-1:0] d, input logic [7:0] sa,
                        input logic dr, input logic ar, input logic [3:0] tg,
                        output int lat, output logic acc, output logic [W-1:0] rd,
                        output logic rs, output logic [3:0] rt);
    logic ov, ir, os;
    logic [W-1:0] od;
    logic [3:0] ot;
    cycle(1'b0, 1'b1, d, sa, dr, ar, tg, 1'b1, ov, ir, od, os, ot);
    acc = ir;
    lat = -1; rd = '0; rs = 1'b0; rt = '0;
    for (int k = 1; k <= 6 && lat < 0; k++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, ov, ir, od, os, ot);
      if (ov) begin lat = k; rd = od; rs = os; rt = ot; end
    end
  endtask

  task automatic test_reset();
    logic ov, ir, os;
    logic [W-1:0] od;
    logic [3:0] ot;
    cycle(1'b1, 1'b1, 24'hABCDEF, 8'd3, 1'b0, 1'b0, 4'h5, 1'b1, ov, ir, od, os, ot);
    cycle(1'b1, 1'b1, 24'hABCDEF, 8'd3, 1'b0, 1'b0, 4'h5, 1'b1, ov, ir, od, os, ot);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, ov, ir, od, os, ot);
    total++;
    if (ov !== 1'b0 || ir !== 1'b1 || od !== '0 || os !== 1'b0 || ot !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%b ready=%b data=%h sticky=%b tag=%h want 0 1 0 0 0",
               ov, ir, od, os, ot);
    end
    // The input offered during reset must not appear later.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, ov, ir, od, os, ot);
      total++;
      if (ov !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_accept: out_valid=%b want 0 (cycle %0d)", ov, k);
      end
    end
  endtask

  task automatic test_single();
    logic [W-1:0] td [3] = '{24'hC00001, 24'h800000, 24'h000003};
    logic [7:0]   ts [3] = '{8'd1, 8'd4, 8'd23};
    logic         tdr[3] = '{1'b0, 1'b0, 1'b1};
    logic         tar[3] = '{1'b0, 1'b1, 1'b0};
    logic [W-1:0] ed [3] = '{24'h600000, 24'hF80000, 24'h800000};
    logic         es [3] = '{1'b1, 1'b0, 1'b1};
    int lat;
    logic acc, rs;
    logic [W-1:0] rd;
    logic [3:0] rt;
    for (int i = 0; i < 3; i++) begin
      one_op(td[i], ts[i], tdr[i], tar[i], 4'(i + 3), lat, acc, rd, rs, rt);
      total++;
      if (acc !== 1'b1 || lat != 2 || rd !== ed[i] || rs !== es[i] || rt !== 4'(i + 3)) begin
        bad++;
        $display("FAIL single_%0d: acc=%b lat=%0d data=%h sticky=%b tag=%h want 1 2 %h %b %h",
                 i, acc, lat, rd, rs, rt, ed[i], es[i], 4'(i + 3));
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] td [4] = '{24'h000010, 24'h800000, 24'h000000, 24'h7FFFFF};
    logic [7:0]   ts [4] = '{8'd30, 8'd200, 8'd255, 8'd24};
    logic         tdr[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic         tar[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] ed [4] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000};
    logic         es [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int lat;
    logic acc, rs;
    logic [W-1:0] rd, d;
    logic [3:0] rt;
    for (int i = 0; i < 4; i++) begin
      one_op(td[i], ts[i], tdr[i], tar[i], 4'(i), lat, acc, rd, rs, rt);
      total++;
      if (lat != 2 || rd !== ed[i] || rs !== es[i]) begin
        bad++;
        $display("FAIL sat_%0d: lat=%0d data=%h sticky=%b want 2 %h %b",
                 i, lat, rd, rs, ed[i], es[i]);
      end
    end
    // A zero amount passes the operand through in every mode.
    for (int m = 0; m < 3; m++) begin
      d = 24'($urandom) | 24'h800001;
      one_op(d, 8'd0, m == 2, m == 1, 4'(m), lat, acc, rd, rs, rt);
      total++;
      if (lat != 2 || rd !== d || rs !== 1'b0) begin
        bad++;
        $display("FAIL amt0_mode%0d: lat=%0d data=%h sticky=%b want 2 %h 0",
                 m, lat, rd, rs, d);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0, last = -1;
    logic v, dr, ar, ov, ir, os;
    logic [W-1:0] d, od;
    logic [7:0] sa;
    logic [3:0] ot;
    while (got < 8 && cyc < 40) begin
      v = sent < 8;
      d = 24'($urandom); sa = 8'($urandom_range(0, 30));
      dr = 1'($urandom); ar = 1'($urandom);
      cycle(1'b0, v, d, sa, dr, ar, 4'(sent), 1'b1, ov, ir, od, os, ot);
      if (ov) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_spurious: out_valid=1 with nothing outstanding");
        end else begin
          e = q.pop_front();
          if (od !== e.d || os !== e.s || ot !== e.t || (last >= 0 && cyc != last + 1)) begin
            bad++;
            $display("FAIL b2b_result: data=%h sticky=%b tag=%h gap=%0d want %h %b %h gap=1",
                     od, os, ot, cyc - last, e.d, e.s, e.t);
          end
        end
        last = cyc; got++;
      end
      if (v) begin
        total++;
        if (ir !== 1'b1) begin
          bad++;
          $display("FAIL b2b_in_ready: in_ready=%b want 1 (op %0d)", ir, sent);
        end
        q.push_back(ref_op(d, sa, dr, ar, 4'(sent)));
        sent++;
      end
      cyc++;
    end
    total++;
    if (got != 8) begin
      bad++;
      $display("FAIL b2b_count: got=%0d want 8", got);
    end
  endtask

  task automatic test_backpressure();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0, stall = 0;
    logic seen = 1'b0;
    logic v, ordy, dr, ar, ov, ir, os, exp_ir;
    logic [W-1:0] d, od, snap_d;
    logic [7:0] sa;
    logic [3:0] ot, snap_t;
    snap_d = '0; snap_t = '0;
    d = 24'($urandom); sa = 8'($urandom_range(0, 30)); dr = 1'($urandom); ar = 1'($urandom);
    while (got < 6 && cyc < 60) begin
      if (!seen && out_valid) begin seen = 1'b1; stall = 4; end
      ordy = (stall == 0);
      v = sent < 6;
      exp_ir = !((sent - got) == 2 && !ordy);
      cycle(1'b0, v, d, sa, dr, ar, 4'(sent), ordy, ov, ir, od, os, ot);
      if (stall == 4) begin snap_d = od; snap_t = ot; end
      if (stall > 0) begin
        total++;
        if (ov !== 1'b1 || od !== snap_d || ot !== snap_t) begin
          bad++;
          $display("FAIL bp_hold: valid=%b data=%h tag=%h want 1 %h %h", ov, od, ot, snap_d, snap_t);
        end
        stall--;
      end
      if (v) begin
        total++;
        if (ir !== exp_ir) begin
          bad++;
          $display("FAIL bp_in_ready: in_ready=%b want %b (in flight %0d)", ir, exp_ir, sent - got);
        end
      end
      if (ov && ordy) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL bp_spurious: out_valid=1 with nothing outstanding");
        end else begin
          e = q.pop_front();
          if (od !== e.d || os !== e.s || ot !== e.t) begin
            bad++;
            $display("FAIL bp_result: data=%h sticky=%b tag=%h want %h %b %h",
                     od, os, ot, e.d, e.s, e.t);
          end
        end
        got++;
      end
      if (v && ir) begin
        q.push_back(ref_op(d, sa, dr, ar, 4'(sent)));
        sent++;
        d = 24'($urandom); sa = 8'($urandom_range(0, 30)); dr = 1'($urandom); ar = 1'($urandom);
      end
      cyc++;
    end
    total++;
    if (got != 6 || q.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got=%0d left=%0d want 6 0", got, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    logic ov, ir, os, acc, rs;
    logic [W-1:0] od, rd;
    logic [3:0] ot, rt;
    int lat;
    cycle(1'b0, 1'b1, 24'h123456, 8'd0, 1'b0, 1'b0, 4'h1, 1'b0, ov, ir, od, os, ot);
    cycle(1'b0, 1'b1, 24'h654321, 8'd4, 1'b0, 1'b0, 4'h2, 1'b0, ov, ir, od, os, ot);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, ov, ir, od, os, ot);
    total++;
    if (ov !== 1'b1 || ir !== 1'b0) begin
      bad++;
      $display("FAIL midrst_full: valid=%b ready=%b want 1 0", ov, ir);
    end
    cycle(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, ov, ir, od, os, ot);
    cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, ov, ir, od, os, ot);
    total++;
    if (ov !== 1'b0 || od !== '0 || os !== 1'b0 || ir !== 1'b1) begin
      bad++;
      $display("FAIL midrst_clear: valid=%b data=%h sticky=%b ready=%b want 0 0 0 1", ov, od, os, ir);
    end
    one_op(24'h0000F1, 8'd4, 1'b0, 1'b0, 4'h9, lat, acc, rd, rs, rt);
    total++;
    if (lat != 2 || rd !== 24'h00000F || rs !== 1'b1 || rt !== 4'h9) begin
      bad++;
      $display("FAIL midrst_next: lat=%0d data=%h sticky=%b tag=%h want 2 00000f 1 9", lat, rd, rs, rt);
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int sent = 0, got = 0, cyc = 0;
    logic v, ordy, dr, ar, ov, ir, os, exp_ir;
    logic [W-1:0] d, od;
    logic [7:0] sa;
    logic [3:0] ot;
    v = 1'b0;
    d = '0; sa = '0; dr = 1'b0; ar = 1'b0;
    while (got < 10000 && cyc < 60000) begin
      // Keep the pending op unchanged until it is accepted.
      if (!v && sent < 10000 && $urandom_range(0, 3) != 0) begin
        v = 1'b1;
        d = 24'($urandom);
        sa = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 26));
        dr = 1'($urandom); ar = 1'($urandom);
      end
      ordy = $urandom_range(0, 9) < 7;
      exp_ir = !((sent - got) == 2 && !ordy);
      cycle(1'b0, v, d, sa, dr, ar, 4'(sent), ordy, ov, ir, od, os, ot);
      total++;
      if (ir !== exp_ir) begin
        bad++;
        $display("FAIL rnd_in_ready: in_ready=%b want %b cycle %0d", ir, exp_ir, cyc);
      end
      if (ov && ordy) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rnd_spurious: out_valid=1 with nothing outstanding cycle %0d", cyc);
        end else begin
          e = q.pop_front();
          if (od !== e.d || os !== e.s || ot !== e.t) begin
            bad++;
            $display("FAIL rnd_result: data=%h sticky=%b tag=%h want %h %b %h (op %0d)",
                     od, os, ot, e.d, e.s, e.t, got);
          end
        end
        got++;
      end
      if (v && ir) begin
        q.push_back(ref_op(d, sa, dr, ar, 4'(sent)));
        sent++;
        v = 1'b0;
      end
      cyc++;
    end
    total++;
    if (got != 10000) begin
      bad++;
      $display("FAIL rnd_count: got=%0d want 10000", got);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_dir = 1'b0;
    in_arith = 1'b0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_saturation();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
